// File: rtl/pdm_capture_packer.sv
// Packs strobed PDM bits LSB-first into words; each RAM write appears one cycle after the completing strobe.
// No backpressure: the RAM accepts every write, so strobes on every cycle lose no samples.
module pdm_capture_packer #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 65536,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pdm_in,
  input  logic                  pdm_strobe,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  circular,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  write_enable,
  output logic [WORD_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int BCW = $clog2(WORD_WIDTH);
  localparam int WCW = ADDR_WIDTH + 1;
  localparam logic [BCW-1:0]        LAST_BIT  = BCW'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [WCW-1:0]        WC_MAX    = WCW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic                    circ_q,     circ_d;
  logic [BCW-1:0]          bit_cnt_q,  bit_cnt_d;
  logic [WORD_WIDTH-1:0]   sr_q,       sr_d;
  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q,  wr_addr_d;
  logic                    wr_en_q,    wr_en_d;
  logic [WORD_WIDTH-1:0]   wr_data_q,  wr_data_d;
  logic                    wrapped_q,  wrapped_d;
  logic [WCW-1:0]          wc_q,       wc_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;

  logic                    begin_rec;
  logic [WORD_WIDTH-1:0]   sr_next;

  // New sample enters at the top so the first sample of a word ends up in bit 0.
  assign sr_next = {pdm_in, sr_q[WORD_WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    circ_d    = circ_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wrapped_d = wrapped_q;
    wc_d      = wc_q;
    begin_rec = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          begin_rec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          // Abort wins over any strobe this cycle; the partial word is dropped.
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          sr_d      = '0;
        end else if (pdm_strobe) begin
          sr_d = sr_next;
          if (bit_cnt_q == LAST_BIT) begin
            wr_en_d   = 1'b1;
            wr_data_d = sr_next;
            wr_addr_d = addr_q;
            bit_cnt_d = '0;
            addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
            if (wc_q != WC_MAX) begin
              wc_d = wc_q + WCW'(1);
            end
            // A saturated count means every address was already written once.
            if (circ_q && (wc_q == WC_MAX)) begin
              wrapped_d = 1'b1;
            end
            if (!circ_q && (addr_q == LAST_ADDR)) begin
              state_d = ST_DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          begin_rec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (begin_rec) begin
      state_d   = ST_CAPTURE;
      circ_d    = circular;
      bit_cnt_d = '0;
      sr_d      = '0;
      addr_d    = '0;
      wrapped_d = 1'b0;
      wc_d      = '0;
    end

    busy_d = (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      circ_q    <= 1'b0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wrapped_q <= 1'b0;
      wc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      circ_q    <= circ_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wrapped_q <= wrapped_d;
      wc_q      <= wc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign write_address = wr_addr_q;
  assign write_enable  = wr_en_q;
  assign write_data    = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wrapped       = wrapped_q;
  assign word_count    = wc_q;

endmodule

// File: tb/tb_pdm_capture_packer.sv
// Bench for pdm_capture_packer with WORD_WIDTH=16, MEM_DEPTH=4.
module tb_pdm_capture_packer;

  localparam int WW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int WCW   = AW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, pdm_in, pdm_strobe, start, stop, circular;
  logic [AW-1:0]  write_address;
  logic           write_enable;
  logic [WW-1:0]  write_data;
  logic           busy, done, wrapped;
  logic [AW:0]    word_count;

  pdm_capture_packer #(.WORD_WIDTH(WW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pdm_in(pdm_in), .pdm_strobe(pdm_strobe),
    .start(start), .stop(stop), .circular(circular),
    .write_address(write_address), .write_enable(write_enable), .write_data(write_data),
    .busy(busy), .done(done), .wrapped(wrapped), .word_count(word_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: recording mode, bits collected so far, total words written.
  int          m_st;      // 0 idle, 1 capture, 2 done
  bit          m_circ;
  bit          m_bits[$];
  int          m_words;
  logic          e_we, e_busy, e_done, e_wrapped;
  logic [AW-1:0] e_wa;
  logic [WW-1:0] e_wd;
  logic [AW:0]   e_wc;

  int          w_addr[$];
  logic [WW-1:0] w_data[$];
  bit          w_wrap[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack_bits();
    logic [WW-1:0] w = '0;
    foreach (m_bits[i]) w[i] = m_bits[i];
    return w;
  endfunction

  task automatic model_begin(input bit ci);
    m_st = 1; m_circ = ci; m_bits.delete(); m_words = 0;
    e_wrapped = 1'b0; e_wc = '0;
  endtask

  task automatic model_edge(input bit r, st, sp, ci, sb, b);
    if (r) begin
      m_st = 0; m_circ = 0; m_bits.delete(); m_words = 0;
      e_we = 0; e_wa = '0; e_wd = '0; e_wrapped = 0; e_wc = '0;
    end else begin
      e_we = 1'b0;
      if (m_st == 0) begin
        if (st && !sp) model_begin(ci);
      end else if (m_st == 2) begin
        if (sp) m_st = 0;
        else if (st) model_begin(ci);
      end else begin
        if (sp) begin
          m_st = 0; m_bits.delete();
        end else if (sb) begin
          m_bits.push_back(b);
          if (m_bits.size() == WW) begin
            e_we = 1'b1;
            e_wa = AW'(m_words % DEPTH);
            e_wd = pack_bits();
            if (m_circ && m_words >= DEPTH) e_wrapped = 1'b1;
            m_words++;
            e_wc = WCW'((m_words >= DEPTH) ? DEPTH : m_words);
            m_bits.delete();
            if (!m_circ && m_words == DEPTH) m_st = 2;
          end
        end
      end
    end
    e_busy = (m_st == 1);
    e_done = (m_st == 2);
  endtask

  task automatic cyc(input bit r, st, sp, ci, sb, b);
    reset = r; start = st; stop = sp; circular = ci; pdm_strobe = sb; pdm_in = b;
    @(posedge clk);
    model_edge(r, st, sp, ci, sb, b);
    #1;
    check("model_outputs",
          {write_enable, write_address, write_data, busy, done, wrapped, word_count},
          {e_we, e_wa, e_wd, e_busy, e_done, e_wrapped, e_wc});
    if (write_enable === 1'b1) begin
      w_addr.push_back(int'(write_address));
      w_data.push_back(write_data);
      w_wrap.push_back(wrapped);
    end
  endtask

  task automatic strobe(input bit b);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    logic rst, st, sp, ci, sb, b;
    logic busy, done, we;
  } vec_t;

  vec_t vecs[10];
  int   pos[$];
  logic [WW-1:0] exp_w1 [4];

  initial begin
    reset = 1'b1; start = 0; stop = 0; circular = 0; pdm_strobe = 0; pdm_in = 0;

    // Control corner cases, one cycle per row: rst st sp ci sb b | busy done we
    vecs[0] = 9'b100000_000;
    vecs[1] = 9'b011000_000;  // start & stop in IDLE
    vecs[2] = 9'b001000_000;
    vecs[3] = 9'b010000_100;  // start
    vecs[4] = 9'b010000_100;  // start ignored while capturing
    vecs[5] = 9'b000011_100;
    vecs[6] = 9'b001000_000;  // stop
    vecs[7] = 9'b000011_000;  // strobe outside capture
    vecs[8] = 9'b010100_100;
    vecs[9] = 9'b000010_100;
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ci, vecs[i].sb, vecs[i].b);
      check($sformatf("vec[%0d]", i), {busy, done, write_enable},
            {vecs[i].busy, vecs[i].done, vecs[i].we});
    end

    // One-shot capture of the index%3 pattern.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_state", {write_enable, write_address, write_data, busy, done, wrapped, word_count}, 0);
    cyc(0, 1, 0, 0, 0, 0);
    w_addr.delete(); w_data.delete(); w_wrap.delete();
    exp_w1[0] = 16'h9249; exp_w1[1] = 16'h4924; exp_w1[2] = 16'h2492; exp_w1[3] = 16'h9249;
    for (int i = 0; i < 64; i++) strobe(i % 3 == 0);
    idle();
    check("oneshot_nwrites", w_addr.size(), 4);
    for (int k = 0; k < 4 && k < w_addr.size(); k++) begin
      check($sformatf("oneshot_addr%0d", k), w_addr[k], k);
      check($sformatf("oneshot_data%0d", k), w_data[k], exp_w1[k]);
    end
    check("oneshot_done_busy_wc", {done, busy, word_count}, {1'b1, 1'b0, 3'd4});

    // Circular: restart from DONE, five all-ones words.
    cyc(0, 1, 0, 1, 0, 0);
    check("circ_start_clear", {busy, done, wrapped, word_count}, {1'b1, 1'b0, 1'b0, 3'd0});
    w_addr.delete(); w_data.delete(); w_wrap.delete();
    for (int i = 0; i < 80; i++) strobe(1'b1);
    check("circ_nwrites", w_addr.size(), 5);
    for (int k = 0; k < 5 && k < w_addr.size(); k++) begin
      check($sformatf("circ_addr%0d", k), w_addr[k], k % DEPTH);
      check($sformatf("circ_data%0d", k), w_data[k], 16'hFFFF);
      check($sformatf("circ_wrap%0d", k), w_wrap[k], k == 4);
    end
    check("circ_busy_wc", {busy, done, word_count}, {1'b1, 1'b0, 3'd4});

    // Abort mid-word, then a fresh word must hold only the new bits.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    w_addr.delete(); w_data.delete(); w_wrap.delete();
    for (int i = 0; i < 10; i++) strobe(1'b1);
    cyc(0, 0, 1, 0, 0, 0);
    check("abort_state", {busy, done, write_enable}, 3'b000);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) strobe(i >= 4 && i < 8);
    check("abort_nwrites", w_addr.size(), 1);
    if (w_addr.size() > 0) begin
      check("abort_addr", w_addr[0], 0);
      check("abort_data", w_data[0], 16'h00F0);
    end

    // Strobe every cycle: one write per 16 strobes, on the cycle after the 16th.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    pos.delete();
    for (int j = 0; j < 64; j++) begin
      strobe(j[0]);
      if (write_enable === 1'b1) pos.push_back(j);
    end
    check("b2b_nwrites", pos.size(), 4);
    for (int k = 0; k < 4 && k < pos.size(); k++) check($sformatf("b2b_pos%0d", k), pos[k], 16 * k + 15);
    idle();
    check("b2b_we_one_cycle", write_enable, 1'b0);

    // start during capture keeps the address; stop on the completing strobe writes nothing.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("start_stop_idle", busy, 1'b0);
    cyc(0, 1, 0, 0, 0, 0);
    w_addr.delete(); w_data.delete(); w_wrap.delete();
    for (int i = 0; i < 20; i++) strobe(1'b0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) strobe(1'b1);
    check("restart_ignored_n", w_addr.size(), 2);
    if (w_addr.size() > 1) check("restart_ignored_addr", w_addr[1], 1);
    for (int i = 0; i < 15; i++) strobe(1'b1);
    cyc(0, 0, 1, 0, 1, 1);
    check("stop_on_complete", {write_enable, busy}, 2'b00);

    // Reset on the completing strobe.
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) strobe(1'b1);
    cyc(1, 0, 0, 0, 1, 1);
    check("reset_on_complete", {write_enable, write_address, write_data, busy, done, wrapped, word_count}, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 119) == 0, $urandom_range(0, 199) == 0,
          1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
